design_select_sequencer: RTL

DESIGN_SELECT_SEQUENCER -- requirements
Module: design_select_sequencer

---
 rtl/design_sel_pkg.sv | 16 +
 rtl/seq_timer.sv | 26 ++
 rtl/design_select_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/design_sel_pkg.sv
// Shared types and constants for the user-design select sequencer.
package design_sel_pkg;

  localparam int NUM_DESIGNS_MAX = 12;
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] DESIGN_NONE = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SWITCH,
    ST_RELEASE,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with a zero flag; the count stops at zero.
module seq_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/design_select_sequencer.sv
// Switches the IO mux between user designs, holding every design in reset
// while the mux moves and releasing only the newly selected one.
//
// state   | meaning
// IDLE    | waiting for a request; rejects or trivially completes some
// DRAIN   | all designs held in reset, outgoing design settling
// SWITCH  | mux moved to the target while everything is still in reset
// RELEASE | target design out of reset, waiting for its synchronizer
// FINISH  | active_design updated, done pulsed
module design_select_sequencer
  import design_sel_pkg::*;
#(
  parameter int NUM_DESIGNS    = 12,
  parameter int SETTLE_CYCLES  = 4,
  parameter int RELEASE_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [IDX_W-1:0]       req_design,
  output logic                   req_ready,
  output logic [NUM_DESIGNS:1]   designs_cs,
  output logic [IDX_W-1:0]       mux_sel,
  output logic [IDX_W-1:0]       active_design,
  output logic                   done,
  output logic                   err
);

  localparam int CNT_MAX = (SETTLE_CYCLES > RELEASE_CYCLES) ? SETTLE_CYCLES : RELEASE_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] RELEASE_LOAD = CW'(RELEASE_CYCLES - 1);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_DESIGNS);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end
  if (RELEASE_CYCLES < 1) begin : g_bad_release
    $error("RELEASE_CYCLES must be at least 1");
  end
  if (NUM_DESIGNS < 1 || NUM_DESIGNS > NUM_DESIGNS_MAX) begin : g_bad_num
    $error("NUM_DESIGNS out of range");
  end

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      target_q, target_d;
  logic [NUM_DESIGNS:1]  cs_q, cs_d;
  logic [IDX_W-1:0]      mux_q, mux_d;
  logic [IDX_W-1:0]      active_q, active_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;

  logic                  tmr_load;
  logic [CW-1:0]         tmr_val;
  logic                  tmr_zero;
  logic [NUM_DESIGNS:1]  release_mask;

  seq_timer #(.W(CW)) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Only the target's bit drops, so at most one design is ever out of reset.
  always_comb begin
    release_mask = '1;
    for (int i = 1; i <= NUM_DESIGNS; i++) begin
      if (IDX_W'(i) == target_q) release_mask[i] = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cs_d     = cs_q;
    mux_d    = mux_q;
    active_d = active_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = SETTLE_LOAD;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          if (req_design > MAX_IDX) begin
            err_d = 1'b1;
          end else if (req_design == active_q) begin
            done_d = 1'b1;
          end else begin
            target_d = req_design;
            cs_d     = '1;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LOAD;
            state_d  = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (tmr_zero) begin
          mux_d   = target_q;
          state_d = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        if (target_q != DESIGN_NONE) begin
          cs_d     = release_mask;
          tmr_load = 1'b1;
          tmr_val  = RELEASE_LOAD;
          state_d  = ST_RELEASE;
        end else begin
          active_d = target_q;
          done_d   = 1'b1;
          state_d  = ST_FINISH;
        end
      end
      ST_RELEASE: begin
        if (tmr_zero) begin
          active_d = target_q;
          done_d   = 1'b1;
          state_d  = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= DESIGN_NONE;
      cs_q     <= '1;
      mux_q    <= DESIGN_NONE;
      active_q <= DESIGN_NONE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cs_q     <= cs_d;
      mux_q    <= mux_d;
      active_q <= active_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign req_ready     = ready_q;
  assign designs_cs    = cs_q;
  assign mux_sel       = mux_q;
  assign active_design = active_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
